// File: rtl/video_ram_arbiter.sv
// Shares one sync video RAM: display fetch owns hc[2:0]==0 active slots, CPU gets the rest.
// Fetch: pix_valid two edges after slot edge; CPU: ack 3 edges after issue, deferred one cycle on a fetch slot.
module video_ram_arbiter #(
  parameter int ADDR_W         = 14,
  parameter int BYTES_PER_LINE = 44
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        hc,
  input  logic [8:0]        vc,
  input  logic              blank,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pix_data,
  output logic              pix_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } cpu_state_t;

  cpu_state_t  state;
  cpu_state_t  state_nxt;
  logic        fetch_slot;
  logic        cpu_issue;
  logic        rdata_load;
  logic [1:0]  fetch_pipe;
  logic [15:0] line_base;
  logic [15:0] fetch_sum;
  logic [ADDR_W-1:0] fetch_addr;

  // 44 = 32 + 8 + 4, so the line base is three shifted copies of vc.
  if (BYTES_PER_LINE == 44) begin : g_shift_base
    assign line_base = ({7'd0, vc} << 5) + ({7'd0, vc} << 3) + ({7'd0, vc} << 2);
  end else begin : g_mul_base
    assign line_base = {7'd0, vc} * 16'(BYTES_PER_LINE);
  end

  assign fetch_sum  = line_base + {10'd0, hc[8:3]};
  assign fetch_addr = ADDR_W'(fetch_sum);
  assign fetch_slot = (hc[2:0] == 3'd0) && !blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cpu_req && !fetch_slot) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requester holds cpu_we stable until ack, so WAIT can still look at it.
  always_comb begin
    cpu_issue  = 1'b0;
    rdata_load = 1'b0;
    cpu_ack    = 1'b0;
    unique case (state)
      IDLE:    cpu_issue  = cpu_req && !fetch_slot;
      WAIT:    rdata_load = !cpu_we;
      ACK:     cpu_ack    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (fetch_slot) begin
      mem_addr <= fetch_addr;
      mem_we   <= 1'b0;
    end else if (cpu_issue) begin
      mem_addr  <= cpu_addr;
      mem_we    <= cpu_we;
      mem_wdata <= cpu_wdata;
    end else begin
      mem_we <= 1'b0;
    end
  end

  // Stage 0: address presented; stage 1: RAM data valid; then it lands in pix_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pipe <= 2'b00;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
    end else begin
      fetch_pipe <= {fetch_pipe[0], fetch_slot};
      pix_valid  <= fetch_pipe[1];
      if (fetch_pipe[1]) begin
        pix_data <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata <= '0;
    end else if (rdata_load) begin
      cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Randomised directed bench for video_ram_arbiter with an event-schedule reference model.
module tb_video_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  hc;
  logic [8:0]  vc;
  logic        blank;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  pix_data;
  logic        pix_valid;

  video_ram_arbiter #(.ADDR_W(14), .BYTES_PER_LINE(44)) dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc), .blank(blank),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  // Framebuffer RAM: synchronous, read-first, one-cycle read latency.
  bit [7:0] ram [16384];
  bit       ram_wr [16384];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_byte(mem_addr);
  end

  // Reference model state
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit sync_run = 0;
  bit [7:0] ref_val [16384];
  bit       ref_wr  [16384];
  int       pix_q_cyc[$];
  logic [7:0] pix_q_dat[$];
  int exp_issue_cyc = -1;
  int exp_ack_cyc   = -1;
  logic        exp_issue_we;
  logic [13:0] exp_issue_addr;
  logic [7:0]  exp_issue_wdata;
  logic [13:0] exp_mem_addr  = '0;
  logic        exp_mem_we    = 1'b0;
  logic [7:0]  exp_mem_wdata = '0;
  logic [7:0]  exp_pix_data  = '0;
  logic [7:0]  exp_rdata     = '0;
  int pix_cnt = 0;
  int we_cnt  = 0;
  int ack_cnt = 0;
  int slot_cnt = 0;

  function automatic logic [7:0] ref_read(input logic [13:0] a);
    return ref_wr[a] ? ref_val[a] : init_byte(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_sync(input int h, input int v);
    hc    = 9'(h);
    vc    = 9'(v);
    blank = (h >= 352) || (v >= 304);
  endtask

  // One clock edge: schedule what the edge must do from the applied inputs, then compare.
  task automatic tick();
    bit slot;
    bit pv;
    int fa;
    int h;
    int v;
    slot = (hc % 8 == 0) && !blank;
    fa   = (int'(vc) * 44 + int'(hc) / 8) % 16384;
    @(posedge clk);
    #1;
    cyc++;
    if (slot) begin
      slot_cnt++;
      exp_mem_addr = 14'(fa);
      exp_mem_we   = 1'b0;
      pix_q_cyc.push_back(cyc + 2);
      pix_q_dat.push_back(ref_read(14'(fa)));
    end else if (cyc == exp_issue_cyc) begin
      exp_mem_addr  = exp_issue_addr;
      exp_mem_we    = exp_issue_we;
      exp_mem_wdata = exp_issue_wdata;
      if (exp_issue_we) begin
        ref_wr[exp_issue_addr]  = 1'b1;
        ref_val[exp_issue_addr] = exp_issue_wdata;
      end
    end else begin
      exp_mem_we = 1'b0;
    end
    chk("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
    chk("mem_we", 32'(mem_we), 32'(exp_mem_we));
    chk("mem_wdata", 32'(mem_wdata), 32'(exp_mem_wdata));
    pv = (pix_q_cyc.size() > 0) && (pix_q_cyc[0] == cyc);
    if (pv) begin
      exp_pix_data = pix_q_dat[0];
      void'(pix_q_cyc.pop_front());
      void'(pix_q_dat.pop_front());
    end
    chk("pix_valid", 32'(pix_valid), 32'(pv));
    chk("pix_data", 32'(pix_data), 32'(exp_pix_data));
    if (cyc == exp_ack_cyc && !exp_issue_we) exp_rdata = ref_read(exp_issue_addr);
    chk("cpu_ack", 32'(cpu_ack), 32'(cyc == exp_ack_cyc));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
    if (pix_valid) pix_cnt++;
    if (mem_we)    we_cnt++;
    if (cpu_ack)   ack_cnt++;
    if (sync_run) begin
      h = int'(hc) + 1;
      v = int'(vc);
      if (h == 448) begin
        h = 0;
        v = (v == 311) ? 0 : v + 1;
      end
      set_sync(h, v);
    end
  endtask

  // Full requester handshake; lat counts edges from raising req to seeing ack.
  task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] d,
                            output int lat, output logic [7:0] rd);
    bit got;
    int r;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_req   = 1'b1;
    r = cyc + 1;
    exp_issue_cyc   = ((hc % 8 == 0) && !blank) ? r + 1 : r;
    exp_issue_we    = we;
    exp_issue_addr  = a;
    exp_issue_wdata = d;
    exp_ack_cyc     = exp_issue_cyc + 2;
    got = 1'b0;
    lat = 0;
    rd  = '0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      lat++;
      if (cpu_ack === 1'b1) begin
        got = 1'b1;
        rd  = cpu_rdata;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    // req is still high at the edge that samples ack, then dropped.
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_ack"}, 32'(cpu_ack), 32'd0);
    chk({pfx, "_rdata"}, 32'(cpu_rdata), 32'd0);
    chk({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({pfx, "_pix_data"}, 32'(pix_data), 32'd0);
    chk({pfx, "_pix_valid"}, 32'(pix_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int d;
    logic [7:0]  rd;
    logic [13:0] a;

    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    set_sync(0, 306);
    @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fetch addressing at the three called-out points
    sync_run = 1'b1;
    set_sync(0, 0);
    tick();
    chk("fetch_addr_0", 32'(mem_addr), 32'd0);
    chk("fetch_we_0", 32'(mem_we), 32'd0);
    tick();
    chk("fetch_pv_e1", 32'(pix_valid), 32'd0);
    tick();
    chk("fetch_pv_e2", 32'(pix_valid), 32'd1);
    chk("fetch_pd_e2", 32'(pix_data), 32'(init_byte(14'd0)));
    repeat (5) tick();
    set_sync(8, 1);
    tick();
    chk("fetch_addr_45", 32'(mem_addr), 32'd45);
    repeat (3) tick();
    set_sync(344, 303);
    tick();
    chk("fetch_addr_13375", 32'(mem_addr), 32'd13375);
    repeat (3) tick();

    // Blank suppression: hblank then vblank
    set_sync(352, 10);
    pix_cnt = 0;
    repeat (96) tick();
    chk("hblank_no_pix", 32'(pix_cnt), 32'd0);
    set_sync(0, 304);
    repeat (64) tick();
    chk("vblank_no_pix", 32'(pix_cnt), 32'd0);

    // CPU write then read in vblank
    set_sync(0, 306);
    we_cnt = 0;
    cpu_access(1'b1, 14'h1234, 8'hA5, lat, rd);
    chk("wr_latency", 32'(lat), 32'd3);
    repeat (2) tick();
    chk("wr_we_pulses", 32'(we_cnt), 32'd1);
    cpu_access(1'b0, 14'h1234, 8'h00, lat, rd);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data", 32'(rd), 32'hA5);

    // Collision: request lands on a fetch slot in the active area
    set_sync(16, 20);
    cpu_access(1'b0, 14'h0100, 8'h00, lat, rd);
    chk("coll_latency", 32'(lat), 32'd4);
    chk("coll_rdata", 32'(rd), 32'(init_byte(14'h0100)));
    repeat (3) tick();

    // Back-to-back random reads with random requester gaps
    set_sync(0, 40);
    ack_cnt = 0;
    pix_cnt = 0;
    slot_cnt = 0;
    for (int n = 0; n < 16; n++) begin
      a = 14'($urandom_range(16383, 0));
      cpu_access(1'b0, a, 8'(n), lat, rd);
      chk("b2b_rdata", 32'(rd), 32'(ref_read(a)));
      d = $urandom_range(3, 0);
      repeat (d) tick();
    end
    set_sync(400, 45);
    repeat (3) tick();
    chk("b2b_acks", 32'(ack_cnt), 32'd16);
    chk("b2b_fetches", 32'(pix_cnt), 32'(slot_cnt));

    // Reset while the FSM sits in WAIT
    set_sync(0, 308);
    cpu_we = 1'b0;
    cpu_addr = 14'h0042;
    cpu_wdata = 8'h5C;
    cpu_req = 1'b1;
    exp_issue_cyc   = cyc + 1;
    exp_issue_we    = 1'b0;
    exp_issue_addr  = 14'h0042;
    exp_issue_wdata = 8'h5C;
    exp_ack_cyc     = cyc + 3;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_zero("midrst");
    cpu_req = 1'b0;
    exp_issue_cyc = -1;
    exp_ack_cyc   = -1;
    exp_mem_addr  = '0;
    exp_mem_we    = 1'b0;
    exp_mem_wdata = '0;
    exp_pix_data  = '0;
    exp_rdata     = '0;
    pix_q_cyc.delete();
    pix_q_dat.delete();
    @(negedge clk);
    rst = 1'b0;
    ack_cnt = 0;
    repeat (8) tick();
    chk("midrst_no_ack", 32'(ack_cnt), 32'd0);
    cpu_access(1'b0, 14'h0042, 8'h00, lat, rd);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_rdata", 32'(rd), 32'(init_byte(14'h0042)));
    repeat (2) tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
